// File: rtl/act_grad_pkg.sv
// Shared types and constants for the Q8.8 activation-gradient unit.
// Function codes, slope codes, segment breakpoints and the stage-1 register layout.
package act_grad_pkg;

  localparam logic [1:0] FN_LRELU = 2'd0;
  localparam logic [1:0] FN_SIG3  = 2'd1;
  localparam logic [1:0] FN_SIG5  = 2'd2;
  localparam logic [1:0] FN_TANH  = 2'd3;

  typedef enum logic [2:0] {
    SL_ONE,
    SL_HALF,
    SL_QTR,
    SL_EIGHTH,
    SL_ZERO,
    SL_ALPHA
  } slope_t;

  localparam logic signed [15:0] BP_64  = 16'sd64;
  localparam logic signed [15:0] BP_192 = 16'sd192;
  localparam logic signed [15:0] BP_448 = 16'sd448;
  localparam logic signed [15:0] BP_512 = 16'sd512;

  localparam logic signed [15:0] ONE = 16'sd256;

  typedef struct packed {
    slope_t             slope;
    logic signed [15:0] g;
    logic signed [15:0] alpha;
    logic               last;
    logic               neg;
  } s1_t;

endpackage

// File: rtl/act_grad_slope_dec.sv
// Segment decoder: maps (func, x) to a slope code, purely combinational.
// Bounds are checked on both signs so x = -32768 needs no abs().
module act_grad_slope_dec
  import act_grad_pkg::*;
(
  input  logic [1:0]  func,
  input  logic [15:0] x,
  output slope_t      slope
);

  logic signed [15:0] sx;
  assign sx = $signed(x);

  always_comb begin
    slope = SL_ZERO;
    case (func)
      FN_LRELU: slope = (sx > 16'sd0) ? SL_ONE : SL_ALPHA;
      FN_SIG3: begin
        if (sx >= -BP_512 && sx <= BP_512) slope = SL_QTR;
      end
      FN_SIG5: begin
        if (sx >= -BP_192 && sx <= BP_192)     slope = SL_QTR;
        else if (sx > -BP_448 && sx < BP_448)  slope = SL_EIGHTH;
      end
      FN_TANH: begin
        if (sx >= -BP_64 && sx <= BP_64)       slope = SL_ONE;
        else if (sx > -BP_192 && sx < BP_192)  slope = SL_HALF;
      end
      default: slope = SL_ZERO;
    endcase
  end

endmodule

// File: rtl/act_grad_q88.sv
// Streaming Q8.8 dx = g * f'(x); clamp + saturation counter under ACT_GRAD_SAT_EN, wrap otherwise.
// Latency 2 cycles, 1 beat/cycle.
// Whole pipeline stalls while out_valid && !out_ready; in_ready = !out_valid || out_ready.
module act_grad_q88
  import act_grad_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_func,
  input  logic [15:0]      in_alpha,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_g,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_dx,
  output logic             out_last,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
);

  logic   adv;
  slope_t dec_slope;
  logic   s1_vld;
  s1_t    s1_dat;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  act_grad_slope_dec u_dec (
    .func  (in_func),
    .x     (in_x),
    .slope (dec_slope)
  );

  // Stage 1: segment decode; func/alpha are resolved here so they travel per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (adv) begin
      s1_vld <= in_valid;
      s1_dat <= '{slope: dec_slope,
                  g:     $signed(in_g),
                  alpha: $signed(in_alpha),
                  last:  in_last,
                  neg:   (in_func == FN_LRELU) && ($signed(in_x) <= 16'sd0)};
    end
  end

  logic signed [31:0] prod;
  logic signed [31:0] prod_sh;
  logic [15:0]        dx_nxt;
  logic               sat_nxt;

  // Stage 2: apply slope. Only the alpha product can exceed 16 bits.
  always_comb begin
    prod    = s1_dat.alpha * s1_dat.g;
    prod_sh = prod >>> 8;
    dx_nxt  = '0;
    sat_nxt = 1'b0;
    if (s1_dat.neg) begin
`ifdef ACT_GRAD_SAT_EN
      if (prod_sh > 32'sd32767) begin
        dx_nxt  = 16'h7FFF;
        sat_nxt = 1'b1;
      end else if (prod_sh < -32'sd32768) begin
        dx_nxt  = 16'h8000;
        sat_nxt = 1'b1;
      end else begin
        dx_nxt  = prod_sh[15:0];
      end
`else
      dx_nxt = prod_sh[15:0];
`endif
    end else begin
      case (s1_dat.slope)
        SL_ONE:    dx_nxt = s1_dat.g;
        SL_HALF:   dx_nxt = s1_dat.g >>> 1;
        SL_QTR:    dx_nxt = s1_dat.g >>> 2;
        SL_EIGHTH: dx_nxt = s1_dat.g >>> 3;
        default:   dx_nxt = '0;
      endcase
    end
  end

  logic s2_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_dx    <= '0;
      out_last  <= 1'b0;
      s2_sat    <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_vld;
      out_dx    <= dx_nxt;
      out_last  <= s1_dat.last;
      s2_sat    <= sat_nxt && s1_vld;
    end
  end

`ifdef ACT_GRAD_SAT_EN
  // Clear beats a simultaneous increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && s2_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end
`else
  assign sat_count = '0;
`endif

endmodule
